// File: rtl/hamming_secded_decoder_if.sv
// Byte-wide data-memory bus shared between the core and the SECDED decoder.
// The master side (the decoder) drives the address, the write strobe and the write data.
// The slave side (the memory) returns read data combinationally, in the same cycle as the address.
interface hamming_secded_decoder_if #(
  parameter int AW = 8
);
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rd_data;
  logic          mem_wr_en;
  logic [7:0]    mem_wr_data;

  modport master (
    output mem_addr,
    output mem_wr_en,
    output mem_wr_data,
    input  mem_rd_data
  );

  modport slave (
    input  mem_addr,
    input  mem_wr_en,
    input  mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/hamming_secded_decoder.sv
// Memory-mapped SECDED decoder for Hamming(16,11) codewords.
//
// The decoder walks NUM_MSG codewords, which sit little-endian at SRC_BASE.
// For each one it corrects a single-bit error or flags a double-bit error.
// It then writes the 11-bit payload and a 2-bit status to DST_BASE.
//
// Codeword bit k is Hamming position k:
//   {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}, where p0 is the overall parity.
//
// Result layout:
//   lo = d[8:1]
//   hi = {flag[1:0], 3'b000, d[11:9]}
//   flag 00 = clean, 01 = corrected, 10 = double error.
//
// Each codeword takes five cycles: RD_LO, RD_HI, DEC, WR_LO, WR_HI.
// Every memory-side output is registered. Each one is loaded on the edge that
// enters the state which uses it, so the address is already valid when the
// combinational read data is sampled.
//
// Optional feature, controlled by the macro SECDED_ERR_CNT_EN:
//   When the macro is defined, the decoder adds the saturating 8-bit counters
//   err1_cnt (corrected codewords) and err2_cnt (double errors).
module hamming_secded_decoder #(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 30,
  parameter int DST_BASE = 0,
  parameter int AW       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  hamming_secded_decoder_if.master mem,
  output logic                     busy,
  output logic                     done
`ifdef SECDED_ERR_CNT_EN
  ,
  output logic [7:0]               err1_cnt,
  output logic [7:0]               err2_cnt
`endif
);

  localparam int            MW       = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
  localparam logic [MW-1:0] LAST_MSG = MW'(NUM_MSG - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_DEC,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [MW-1:0] r_msg;
  logic [15:0]   r_cw;
  logic [7:0]    r_res_hi;
  logic [AW-1:0] r_addr;
  logic          r_wr_en;
  logic [7:0]    r_wr_data;
  logic          r_busy;
  logic          r_done;
`ifdef SECDED_ERR_CNT_EN
  logic [7:0]    r_err1_cnt;
  logic [7:0]    r_err2_cnt;
`endif

  logic [12:0]   w_dec;
  logic [1:0]    w_flag;
  logic [10:0]   w_data;

  // Byte address of codeword/result idx. The address wraps modulo 2^AW.
  function automatic logic [AW-1:0] f_addr(input int base, input logic [MW-1:0] idx);
    int a;
    a = base + 2 * int'(idx);
    return AW'(a);
  endfunction

  // Saturating increment for the error counters.
  function automatic logic [7:0] f_sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // SECDED decode. The result is {flag[1:0], d11..d1}.
  // The syndrome is the XOR of the positions of all set bits.
  // When the overall parity is odd, exactly one bit is assumed flipped, and the
  // syndrome names it. A syndrome of zero means p0 itself flipped, so the data is untouched.
  // When the parity is even but the syndrome is nonzero, two bits flipped.
  // That cannot be located, so the data is passed through raw.
  function automatic logic [12:0] f_decode(input logic [15:0] cw);
    logic [3:0]  syn;
    logic        par;
    logic [15:0] fix;
    logic [1:0]  flag;
    syn = 4'd0;
    for (int k = 1; k < 16; k++) begin
      if (cw[k]) syn = syn ^ 4'(k);
    end
    par  = ^cw;
    fix  = cw;
    flag = 2'b00;
    if (par) begin
      flag     = 2'b01;
      fix[syn] = ~fix[syn];
    end else if (syn != 4'd0) begin
      flag = 2'b10;
    end
    return {flag, fix[15:9], fix[7:5], fix[3]};
  endfunction

  assign w_dec  = f_decode(r_cw);
  assign w_flag = w_dec[12:11];
  assign w_data = w_dec[10:0];

  assign mem.mem_addr    = r_addr;
  assign mem.mem_wr_en   = r_wr_en;
  assign mem.mem_wr_data = r_wr_data;
  assign busy            = r_busy;
  assign done            = r_done;
`ifdef SECDED_ERR_CNT_EN
  assign err1_cnt        = r_err1_cnt;
  assign err2_cnt        = r_err2_cnt;
`endif

  // Control FSM. It also registers every memory-side output and the status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_msg      <= '0;
      r_cw       <= '0;
      r_res_hi   <= '0;
      r_addr     <= '0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef SECDED_ERR_CNT_EN
      r_err1_cnt <= '0;
      r_err2_cnt <= '0;
`endif
    end else begin
      case (r_state)
        // Accept a start. A start held high in DONE begins the next run at once.
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_RD_LO;
            r_msg      <= '0;
            r_addr     <= f_addr(SRC_BASE, '0);
            r_wr_en    <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
`ifdef SECDED_ERR_CNT_EN
            r_err1_cnt <= '0;
            r_err2_cnt <= '0;
`endif
          end
        end

        // Low codeword byte is on the read bus; move on to the high byte.
        S_RD_LO: begin
          r_cw[7:0] <= mem.mem_rd_data;
          r_addr    <= r_addr + AW'(1);
          r_state   <= S_RD_HI;
        end

        // High codeword byte is on the read bus.
        S_RD_HI: begin
          r_cw[15:8] <= mem.mem_rd_data;
          r_state    <= S_DEC;
        end

        // Decode the codeword, then set up the write of the low result byte.
        S_DEC: begin
          r_res_hi  <= {w_flag, 3'b000, w_data[10:8]};
          r_addr    <= f_addr(DST_BASE, r_msg);
          r_wr_en   <= 1'b1;
          r_wr_data <= w_data[7:0];
          r_state   <= S_WR_LO;
`ifdef SECDED_ERR_CNT_EN
          if (w_flag == 2'b01) r_err1_cnt <= f_sat_inc(r_err1_cnt);
          if (w_flag == 2'b10) r_err2_cnt <= f_sat_inc(r_err2_cnt);
`endif
        end

        // Low result byte is being written; set up the write of the high byte.
        S_WR_LO: begin
          r_addr    <= r_addr + AW'(1);
          r_wr_data <= r_res_hi;
          r_state   <= S_WR_HI;
        end

        // High result byte is being written; go to the next codeword or finish.
        S_WR_HI: begin
          r_wr_en <= 1'b0;
          if (r_msg == LAST_MSG) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_msg   <= r_msg + MW'(1);
            r_addr  <= f_addr(SRC_BASE, r_msg + MW'(1));
            r_state <= S_RD_LO;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_wr_en <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed bench for hamming_secded_decoder, with a byte-wide memory model on the bus.
// It covers the reset state, the hand-computed decode vectors, randomly corrupted
// encoder-model codewords with start pulses during the run, and an abort by reset
// during message 7 followed by a clean restart.
module tb_hamming_secded_decoder;
  localparam int NUM_MSG  = 15;
  localparam int SRC_BASE = 30;
  localparam int DST_BASE = 0;
  localparam int AW       = 8;
  localparam int RUN_CYC  = 5 * NUM_MSG;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;
`ifdef SECDED_ERR_CNT_EN
  logic [7:0] err1_cnt;
  logic [7:0] err2_cnt;
`endif

  hamming_secded_decoder_if #(.AW(AW)) bus ();

  hamming_secded_decoder #(
    .NUM_MSG (NUM_MSG),
    .SRC_BASE(SRC_BASE),
    .DST_BASE(DST_BASE),
    .AW      (AW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mem     (bus),
    .busy    (busy),
    .done    (done)
`ifdef SECDED_ERR_CNT_EN
    ,
    .err1_cnt(err1_cnt),
    .err2_cnt(err2_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: combinational read and a write at posedge.
  // It also counts the writes, and counts any write made while the decoder is not busy.
  logic [7:0] mem [0:255];
  int wr_cnt = 0;
  int bad_wr = 0;
  assign bus.mem_rd_data = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (bus.mem_wr_en === 1'b1) begin
      mem[bus.mem_addr] = bus.mem_wr_data;
      wr_cnt++;
      if (busy !== 1'b1) bad_wr++;
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] cw_v   [NUM_MSG];
  logic [7:0]  exp_lo [NUM_MSG];
  logic [7:0]  exp_hi [NUM_MSG];
  int e1;
  int e2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Golden Hamming(16,11) encoder: places the data bits, then fills p1/p2/p4/p8 and p0.
  function automatic logic [15:0] enc(input logic [10:0] d);
    logic [15:0] c;
    logic        p;
    int          pj;
    c       = '0;
    c[3]    = d[0];
    c[7:5]  = d[3:1];
    c[15:9] = d[10:4];
    for (int j = 0; j < 4; j++) begin
      pj = 1 << j;
      p  = 1'b0;
      for (int k = 1; k < 16; k++) begin
        if (((k & pj) != 0) && (k != pj)) p = p ^ c[k];
      end
      c[pj] = p;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic logic [10:0] ext(input logic [15:0] c);
    return {c[15:9], c[7:5], c[3]};
  endfunction

  task automatic load_mem();
    for (int i = 0; i < NUM_MSG; i++) begin
      mem[SRC_BASE + 2*i]     = cw_v[i][7:0];
      mem[SRC_BASE + 2*i + 1] = cw_v[i][15:8];
      mem[DST_BASE + 2*i]     = 8'hAA;
      mem[DST_BASE + 2*i + 1] = 8'hAA;
    end
  endtask

  // Start a run, optionally pulse start at the given cycle offsets, and count cycles until done.
  task automatic run_msgs(input int pa, input int pb, output int cycles, output logic busy_acc);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    busy_acc = busy;
    cycles   = 0;
    while (done !== 1'b1 && cycles < 200) begin
      if (cycles == pa || cycles == pb) start = 1'b1;
      else start = 1'b0;
      @(posedge clk);
      #1;
      cycles++;
    end
    start = 1'b0;
  endtask

  task automatic check_results(input int upto);
    for (int i = 0; i < NUM_MSG; i++) begin
      if (i < upto) begin
        check($sformatf("lo%0d", i), mem[DST_BASE + 2*i],     exp_lo[i]);
        check($sformatf("hi%0d", i), mem[DST_BASE + 2*i + 1], exp_hi[i]);
      end else begin
        check($sformatf("untouched_lo%0d", i), mem[DST_BASE + 2*i],     8'hAA);
        check($sformatf("untouched_hi%0d", i), mem[DST_BASE + 2*i + 1], 8'hAA);
      end
    end
  endtask

  initial begin
    int          cyc;
    logic        bacc;
    logic [10:0] d;
    logic [15:0] c;
    int          nf;
    int          a;
    int          b;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr",    bus.mem_addr,    8'h00);
    check("rst_wr_en",   bus.mem_wr_en,   1'b0);
    check("rst_wr_data", bus.mem_wr_data, 8'h00);
    check("rst_busy",    busy,            1'b0);
    check("rst_done",    done,            1'b0);
`ifdef SECDED_ERR_CNT_EN
    check("rst_err1", err1_cnt, 8'h00);
    check("rst_err2", err2_cnt, 8'h00);
`endif
    @(negedge clk);
    reset = 1'b1;

    // Run A: hand-computed vectors (clean, single data bit, p0 only, double error).
    cw_v[0] = 16'h000F; exp_lo[0] = 8'h01; exp_hi[0] = 8'h00;
    cw_v[1] = 16'h020F; exp_lo[1] = 8'h01; exp_hi[1] = 8'h40;
    cw_v[2] = 16'h000E; exp_lo[2] = 8'h01; exp_hi[2] = 8'h40;
    cw_v[3] = 16'h1007; exp_lo[3] = 8'h80; exp_hi[3] = 8'h80;
    for (int i = 4; i < NUM_MSG; i++) begin
      cw_v[i] = 16'h000F; exp_lo[i] = 8'h01; exp_hi[i] = 8'h00;
    end
    load_mem();
    wr_cnt = 0;
    run_msgs(-1, -1, cyc, bacc);
    check("A_busy_after_accept", bacc, 1'b1);
    check("A_done_latency", cyc, RUN_CYC);
    check("A_busy_at_done", busy, 1'b0);
    check("A_wr_count", wr_cnt, 2 * NUM_MSG);
    check_results(NUM_MSG);
`ifdef SECDED_ERR_CNT_EN
    check("A_err1", err1_cnt, 8'd2);
    check("A_err2", err2_cnt, 8'd1);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("A_done_held", done, 1'b1);

    // Run B: encoder-model codewords with 0/1/2 random flips; start pulsed while busy.
    e1 = 0;
    e2 = 0;
    for (int i = 0; i < NUM_MSG; i++) begin
      d  = 11'($urandom_range(0, 2047));
      nf = int'($urandom_range(0, 2));
      if (i == 0) nf = 0;
      if (i == 1) nf = 1;
      if (i == 2) nf = 2;
      c  = enc(d);
      a  = int'($urandom_range(0, 15));
      b  = (a + int'($urandom_range(1, 15))) % 16;
      if (nf >= 1) c[a] = ~c[a];
      if (nf == 2) c[b] = ~c[b];
      cw_v[i] = c;
      if (nf == 0) begin
        exp_lo[i] = d[7:0];
        exp_hi[i] = {2'b00, 3'b000, d[10:8]};
      end else if (nf == 1) begin
        exp_lo[i] = d[7:0];
        exp_hi[i] = {2'b01, 3'b000, d[10:8]};
        e1++;
      end else begin
        exp_lo[i] = ext(c)[7:0];
        exp_hi[i] = {2'b10, 3'b000, ext(c)[10:8]};
        e2++;
      end
    end
    load_mem();
    wr_cnt = 0;
    run_msgs(20, 41, cyc, bacc);
    check("B_busy_after_accept", bacc, 1'b1);
    check("B_done_latency", cyc, RUN_CYC);
    check("B_wr_count", wr_cnt, 2 * NUM_MSG);
    check_results(NUM_MSG);
`ifdef SECDED_ERR_CNT_EN
    check("B_err1", err1_cnt, e1);
    check("B_err2", err2_cnt, e2);
`endif

    // Run C: reset during message 7 (its RD_HI cycle), then restart from a clean state.
    load_mem();
    wr_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (36) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_addr",    bus.mem_addr,    8'h00);
    check("abort_wr_en",   bus.mem_wr_en,   1'b0);
    check("abort_wr_data", bus.mem_wr_data, 8'h00);
    check("abort_busy",    busy,            1'b0);
    check("abort_done",    done,            1'b0);
`ifdef SECDED_ERR_CNT_EN
    check("abort_err1", err1_cnt, 8'h00);
    check("abort_err2", err2_cnt, 8'h00);
`endif
    repeat (4) @(posedge clk);
    #1;
    check("abort_wr_count", wr_cnt, 14);
    check_results(7);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort_idle_busy", busy, 1'b0);
    load_mem();
    wr_cnt = 0;
    run_msgs(-1, -1, cyc, bacc);
    check("C_busy_after_accept", bacc, 1'b1);
    check("C_done_latency", cyc, RUN_CYC);
    check("C_wr_count", wr_cnt, 2 * NUM_MSG);
    check_results(NUM_MSG);
`ifdef SECDED_ERR_CNT_EN
    check("C_err1", err1_cnt, e1);
    check("C_err2", err2_cnt, e2);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("wr_outside_run", bad_wr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
